calendar_timer: RTL and testbench
=================================

Name: calendar_timer

Overview:
- Parameterised real-time calendar counter: seconds, minutes, hours, day, month, year, with a programmable tick prescaler.
- Adds full Gregorian leap-year handling, a run/pause control, a validated synchronous load port and a per-second strobe.
- Sits at system top as the timebase for display and alarm logic; a debug bench clocks it at one tick per cycle.

Parameters:
- TICKS_PER_SEC, 1: clk cycles per second; must be >= 1.
- YEAR_W, 14: year field width.
- YEAR_MAX, 9999: last valid year; the year after it wraps to 0. Must be < 2**YEAR_W.
- RST_YEAR, 2000: year value loaded by reset.

Ports:
- clk  in  1  system clock, rising edge
- glob_rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = count, 0 = hold all fields and the prescaler
- load  in  1  single-cycle request to load ld_* fields
- ld_sec  in  6  load value, seconds 0..59
- ld_min  in  6  load value, minutes 0..59
- ld_hour  in  5  load value, hours 0..23
- ld_day  in  5  load value, day 1..days_in_month(ld_mon, ld_year)
- ld_mon  in  4  load value, month 1..12
- ld_year  in  YEAR_W  load value, year 0..YEAR_MAX
- sec  out  6  current second
- min  out  6  current minute
- hour  out  5  current hour
- day  out  5  current day of month, 1-based
- mon  out  4  current month, 1-based
- year  out  YEAR_W  current year
- sec_tick  out  1  one-cycle pulse on the cycle the seconds field advances
- load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (asynchronous, glob_rst_n=0): sec=0, min=0, hour=0, day=1, mon=1, year=RST_YEAR, prescaler=0, sec_tick=0, load_err=0.
- All outputs are registered.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 while run=1.
  - An advance occurs on the edge where prescaler==TICKS_PER_SEC-1 and run=1; the prescaler returns to 0 on that edge.
  - With TICKS_PER_SEC=1 every run cycle is an advance.
- Advance cascade (single edge, no multi-cycle ripple):
  - sec 59 -> 0 carries to min; min 59 -> 0 carries to hour; hour 23 -> 0 carries to day.
  - day == days_in_month -> 1 carries to mon.
  - mon 12 -> 1 carries to year; year YEAR_MAX -> 0.
- days_in_month:
  - 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11.
  - Month 2: 29 if leap, else 28.
  - leap = (year%4==0 && year%100!=0) || year%400==0. Year 0 is leap.
- sec_tick:
  - Registered; asserted in the cycle after the advancing edge.
  - Therefore coincident with the new sec value being visible.
- run=0: all fields and the prescaler hold, sec_tick=0; counting resumes from the held prescaler value.
- Load:
  - Sampled on the edge where load=1. Valid when every ld_* field is in range, with day checked against days_in_month(ld_mon, ld_year).
  - Valid load: all fields take the ld_* values, prescaler=0, no sec_tick for that cycle.
  - Invalid load: fields unchanged, load_err=1 for one cycle, and the prescaler and advance proceed normally.
  - Load works regardless of run.
- Load and advance on the same edge: a valid load wins and the advance is dropped.
- Reset mid-count or mid-load: immediate return to reset values; a pending load is discarded.

Optional Feature:
- Macro: CALENDAR_TIMER_ALARM_EN.
- When defined, three extra ports:
  - al_hour  in  5
  - al_min  in  6
  - alarm  out  1
- alarm is a one-cycle registered pulse, same timing as sec_tick, when an advance produces hour==al_hour, min==al_min, sec==0.
- A valid load that lands exactly on al_hour:al_min:00 does not fire alarm. alarm resets to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, run=1, TICKS_PER_SEC=1, 86400 cycles -> 2000-01-02 00:00:00; sec_tick seen 86400 times.
- Load 2024-02-28 23:59:59, one advance -> 2024-02-29 00:00:00. Load 2100-02-28 23:59:59, one advance -> 2100-03-01 00:00:00. Load 2000-02-28 23:59:59, one advance -> 2000-02-29.
- Load 9999-12-31 23:59:59, one advance -> year 0, mon 1, day 1, time 00:00:00.
- Load 2023-02-29 00:00:00 -> load_err pulse 1 cycle, fields unchanged. Load mon=13 -> load_err. Load sec=60 -> load_err.
- TICKS_PER_SEC=4: run=1 for 3 cycles, run=0 for 5 cycles, run=1 for 1 cycle -> sec increments once after that cycle. Load asserted on the advancing edge -> loaded value held, no sec_tick.
- CALENDAR_TIMER_ALARM_EN defined, al_hour=7, al_min=30: load 07:29:59, advance -> alarm pulse 1 cycle. Direct load of 07:30:00 -> no alarm. Assert glob_rst_n=0 mid-run -> immediate reset values.

Source files
------------

// File: rtl/calendar_timer.sv
// calendar_timer: prescaled real-time calendar (sec/min/hour/day/mon/year)
// with Gregorian leap years, run/pause, validated load and per-second strobe.
// Optional alarm comparator: define CALENDAR_TIMER_ALARM_EN.
module calendar_timer #(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned YEAR_W        = 14,
  parameter int unsigned YEAR_MAX      = 9999,
  parameter int unsigned RST_YEAR      = 2000
) (
  input  logic              clk,
  input  logic              glob_rst_n,
  input  logic              run,
  input  logic              load,
  input  logic [5:0]        ld_sec,
  input  logic [5:0]        ld_min,
  input  logic [4:0]        ld_hour,
  input  logic [4:0]        ld_day,
  input  logic [3:0]        ld_mon,
  input  logic [YEAR_W-1:0] ld_year,
`ifdef CALENDAR_TIMER_ALARM_EN
  input  logic [4:0]        al_hour,
  input  logic [5:0]        al_min,
  output logic              alarm,
`endif
  output logic [5:0]        sec,
  output logic [5:0]        min,
  output logic [4:0]        hour,
  output logic [4:0]        day,
  output logic [3:0]        mon,
  output logic [YEAR_W-1:0] year,
  output logic              sec_tick,
  output logic              load_err
);

  localparam int unsigned       PS_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PS_W-1:0]   PS_LAST = PS_W'(TICKS_PER_SEC - 1);
  localparam logic [YEAR_W-1:0] YMAX    = YEAR_W'(YEAR_MAX);

  logic [PS_W-1:0]   r_ps;
  logic [5:0]        r_sec, r_min;
  logic [4:0]        r_hour, r_day;
  logic [3:0]        r_mon;
  logic [YEAR_W-1:0] r_year;
  logic              r_tick, r_load_err;

  logic              w_adv, w_ld_ok;
  logic [4:0]        w_dim, w_ld_dim;
  logic              w_c_sec, w_c_min, w_c_hour, w_c_day, w_c_mon;
  logic [5:0]        w_n_sec, w_n_min;
  logic [4:0]        w_n_hour, w_n_day;
  logic [3:0]        w_n_mon;
  logic [YEAR_W-1:0] w_n_year;

  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    int unsigned v;
    v = 32'(y);
    return (((v % 4) == 0) && ((v % 100) != 0)) || ((v % 400) == 0);
  endfunction

  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic [YEAR_W-1:0] y);
    case (m)
      4'd2:                     return is_leap(y) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:  return 5'd30;
      default:                  return 5'd31;
    endcase
  endfunction

  // Advance decision and load validation
  always_comb begin
    w_adv    = run && (r_ps == PS_LAST);
    w_dim    = days_in_month(r_mon, r_year);
    w_ld_dim = days_in_month(ld_mon, ld_year);
    w_ld_ok  = load
             && (ld_sec < 6'd60) && (ld_min < 6'd60) && (ld_hour < 5'd24)
             && (ld_mon != 4'd0) && (ld_mon <= 4'd12)
             && (ld_day != 5'd0) && (ld_day <= w_ld_dim)
             && (ld_year <= YMAX);
  end

  // Single-edge carry cascade: each field's next value depends on all lower carries
  always_comb begin
    w_c_sec  = (r_sec == 6'd59);
    w_c_min  = w_c_sec && (r_min == 6'd59);
    w_c_hour = w_c_min && (r_hour == 5'd23);
    w_c_day  = w_c_hour && (r_day == w_dim);
    w_c_mon  = w_c_day && (r_mon == 4'd12);
    w_n_sec  = w_c_sec ? '0 : r_sec + 6'd1;
    w_n_min  = w_c_sec ? ((r_min == 6'd59) ? '0 : r_min + 6'd1) : r_min;
    w_n_hour = w_c_min ? ((r_hour == 5'd23) ? '0 : r_hour + 5'd1) : r_hour;
    w_n_day  = w_c_hour ? ((r_day == w_dim) ? 5'd1 : r_day + 5'd1) : r_day;
    w_n_mon  = w_c_day ? ((r_mon == 4'd12) ? 4'd1 : r_mon + 4'd1) : r_mon;
    w_n_year = w_c_mon ? ((r_year == YMAX) ? '0 : r_year + YEAR_W'(1)) : r_year;
  end

  // Calendar registers, prescaler and strobes; a valid load overrides any advance
  always_ff @(posedge clk or negedge glob_rst_n) begin
    if (!glob_rst_n) begin
      r_ps       <= '0;
      r_sec      <= '0;
      r_min      <= '0;
      r_hour     <= '0;
      r_day      <= 5'd1;
      r_mon      <= 4'd1;
      r_year     <= YEAR_W'(RST_YEAR);
      r_tick     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= load && !w_ld_ok;
      if (w_ld_ok) begin
        r_ps   <= '0;
        r_sec  <= ld_sec;
        r_min  <= ld_min;
        r_hour <= ld_hour;
        r_day  <= ld_day;
        r_mon  <= ld_mon;
        r_year <= ld_year;
        r_tick <= 1'b0;
      end else begin
        r_tick <= w_adv;
        if (run) r_ps <= w_adv ? '0 : r_ps + PS_W'(1);
        if (w_adv) begin
          r_sec  <= w_n_sec;
          r_min  <= w_n_min;
          r_hour <= w_n_hour;
          r_day  <= w_n_day;
          r_mon  <= w_n_mon;
          r_year <= w_n_year;
        end
      end
    end
  end

`ifdef CALENDAR_TIMER_ALARM_EN
  logic r_alarm;
  logic w_al_hit;

  // Alarm matches the post-advance time, so only counting can reach it
  always_comb begin
    w_al_hit = w_adv && !w_ld_ok && (w_n_sec == 6'd0)
             && (w_n_min == al_min) && (w_n_hour == al_hour);
  end

  // Alarm strobe, timed like sec_tick
  always_ff @(posedge clk or negedge glob_rst_n) begin
    if (!glob_rst_n) r_alarm <= 1'b0;
    else             r_alarm <= w_al_hit;
  end

  assign alarm = r_alarm;
`endif

  assign sec      = r_sec;
  assign min      = r_min;
  assign hour     = r_hour;
  assign day      = r_day;
  assign mon      = r_mon;
  assign year     = r_year;
  assign sec_tick = r_tick;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_calendar_timer.sv
// Scoreboard bench for calendar_timer: two instances (1 and 4 ticks/second).
// Stimulus pushes expected events/snapshots; one monitor pops and compares.
module tb_calendar_timer;

  typedef struct packed {
    logic        tick;
    logic        err;
    logic        alarm;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [4:0]  hour;
    logic [4:0]  day;
    logic [3:0]  mon;
    logic [13:0] year;
  } rec_t;

`ifdef CALENDAR_TIMER_ALARM_EN
  localparam logic AL = 1'b1;
`else
  localparam logic AL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run1, load1, run4, load4;
  logic [5:0]  ld_sec, ld_min;
  logic [4:0]  ld_hour, ld_day;
  logic [3:0]  ld_mon;
  logic [13:0] ld_year;
  logic [5:0]  sec1, min1, sec4, min4;
  logic [4:0]  hour1, day1, hour4, day4;
  logic [3:0]  mon1, mon4;
  logic [13:0] year1, year4;
  logic        tick1, err1, tick4, err4;
  logic        alarm1, alarm4;

  always #5 clk = ~clk;

  calendar_timer #(.TICKS_PER_SEC(1), .YEAR_W(14), .YEAR_MAX(9999), .RST_YEAR(2000)) u_dut1 (
    .clk(clk), .glob_rst_n(rst_n), .run(run1), .load(load1),
    .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour), .ld_day(ld_day),
    .ld_mon(ld_mon), .ld_year(ld_year),
`ifdef CALENDAR_TIMER_ALARM_EN
    .al_hour(5'd7), .al_min(6'd30), .alarm(alarm1),
`endif
    .sec(sec1), .min(min1), .hour(hour1), .day(day1), .mon(mon1), .year(year1),
    .sec_tick(tick1), .load_err(err1));

  calendar_timer #(.TICKS_PER_SEC(4), .YEAR_W(14), .YEAR_MAX(9999), .RST_YEAR(2000)) u_dut4 (
    .clk(clk), .glob_rst_n(rst_n), .run(run4), .load(load4),
    .ld_sec(ld_sec), .ld_min(ld_min), .ld_hour(ld_hour), .ld_day(ld_day),
    .ld_mon(ld_mon), .ld_year(ld_year),
`ifdef CALENDAR_TIMER_ALARM_EN
    .al_hour(5'd7), .al_min(6'd30), .alarm(alarm4),
`endif
    .sec(sec4), .min(min4), .hour(hour4), .day(day4), .mon(mon4), .year(year4),
    .sec_tick(tick4), .load_err(err4));

`ifndef CALENDAR_TIMER_ALARM_EN
  assign alarm1 = 1'b0;
  assign alarm4 = 1'b0;
`endif

  rec_t        q1[$], q4[$], snap1[$], snap4[$];
  int unsigned cnt_q[$];
  int unsigned n_cmp = 0, n_fail = 0, n_tick1 = 0;
  logic        strict = 1'b0, req_drain = 1'b0, drained = 1'b0;
  rec_t        a1, a4, e, cur1;
  int unsigned ec;

  function automatic rec_t mk(input logic t, input logic er, input logic al,
                              input int y, input int mo, input int d,
                              input int h, input int mi, input int s);
    rec_t r;
    r.tick = t; r.err = er; r.alarm = al;
    r.sec = 6'(s); r.min = 6'(mi); r.hour = 5'(h);
    r.day = 5'(d); r.mon = 4'(mo); r.year = 14'(y);
    return r;
  endfunction

  function automatic string fmt(input rec_t r);
    return $sformatf("tick=%0b err=%0b alarm=%0b %0d-%0d-%0d %0d:%0d:%0d",
                     r.tick, r.err, r.alarm, r.year, r.mon, r.day, r.hour, r.min, r.sec);
  endfunction

  // Monitor: all comparisons happen here, at the falling edge
  always @(negedge clk) begin
    a1 = {tick1, err1, alarm1, sec1, min1, hour1, day1, mon1, year1};
    a4 = {tick4, err4, alarm4, sec4, min4, hour4, day4, mon4, year4};
    if (rst_n && tick1) n_tick1++;
    if (cnt_q.size() > 0) begin
      ec = cnt_q.pop_front();
      n_cmp++;
      if (n_tick1 != ec) begin
        n_fail++;
        $display("FAIL tick_count: got %0d want %0d", n_tick1, ec);
      end
    end
    if (rst_n && strict && (a1.tick || a1.err || a1.alarm)) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL event1_unexpected: got %s want no event", fmt(a1));
      end else begin
        e = q1.pop_front();
        if (a1 !== e) begin
          n_fail++;
          $display("FAIL event1: got %s want %s", fmt(a1), fmt(e));
        end
      end
    end
    if (rst_n && strict && (a4.tick || a4.err || a4.alarm)) begin
      n_cmp++;
      if (q4.size() == 0) begin
        n_fail++;
        $display("FAIL event4_unexpected: got %s want no event", fmt(a4));
      end else begin
        e = q4.pop_front();
        if (a4 !== e) begin
          n_fail++;
          $display("FAIL event4: got %s want %s", fmt(a4), fmt(e));
        end
      end
    end
    if (snap1.size() > 0) begin
      e = snap1.pop_front();
      n_cmp++;
      if (a1 !== e) begin
        n_fail++;
        $display("FAIL snap1: got %s want %s", fmt(a1), fmt(e));
      end
    end
    if (snap4.size() > 0) begin
      e = snap4.pop_front();
      n_cmp++;
      if (a4 !== e) begin
        n_fail++;
        $display("FAIL snap4: got %s want %s", fmt(a4), fmt(e));
      end
    end
    if (req_drain && !drained) begin
      drained = 1'b1;
      n_cmp++;
      if ((q1.size() + q4.size() + snap1.size() + snap4.size() + cnt_q.size()) != 0) begin
        n_fail++;
        $display("FAIL drain: got %0d/%0d events pending want 0/0", q1.size(), q4.size());
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ld(input int y, input int mo, input int d, input int h, input int mi, input int s);
    ld_year = 14'(y); ld_mon = 4'(mo); ld_day = 5'(d);
    ld_hour = 5'(h); ld_min = 6'(mi); ld_sec = 6'(s);
  endtask

  // Valid load with run low, then exactly one advancing cycle
  task automatic adv(input int y, input int mo, input int d, input int h, input int mi, input int s,
                     input int ey, input int emo, input int ed, input int eh, input int emi,
                     input int es, input logic eal);
    set_ld(y, mo, d, h, mi, s);
    load1 = 1'b1; run1 = 1'b0;
    step(1);
    snap1.push_back(mk(1'b0, 1'b0, 1'b0, y, mo, d, h, mi, s));
    load1 = 1'b0; run1 = 1'b1;
    cur1 = mk(1'b1, 1'b0, eal, ey, emo, ed, eh, emi, es);
    q1.push_back(cur1);
    step(1);
    run1 = 1'b0;
    step(1);
  endtask

  task automatic bad_load(input int y, input int mo, input int d, input int h, input int mi, input int s);
    rec_t r;
    set_ld(y, mo, d, h, mi, s);
    r = cur1; r.tick = 1'b0; r.err = 1'b1; r.alarm = 1'b0;
    q1.push_back(r);
    load1 = 1'b1; run1 = 1'b0;
    step(1);
    load1 = 1'b0;
    step(1);
  endtask

  initial begin
    rst_n = 1'b0; run1 = 1'b0; load1 = 1'b0; run4 = 1'b0; load4 = 1'b0;
    set_ld(0, 0, 0, 0, 0, 0);
    step(2);
    rst_n = 1'b1;
    snap1.push_back(mk(1'b0, 1'b0, 1'b0, 2000, 1, 1, 0, 0, 0));
    snap4.push_back(mk(1'b0, 1'b0, 1'b0, 2000, 1, 1, 0, 0, 0));
    step(1);

    // One full day at one tick per cycle
    run1 = 1'b1;
    step(86400);
    run1 = 1'b0;
    snap1.push_back(mk(1'b1, 1'b0, 1'b0, 2000, 1, 2, 0, 0, 0));
    cnt_q.push_back(86400);
    step(2);

    strict = 1'b1;
    adv(2024, 2, 28, 23, 59, 59,  2024, 2, 29, 0, 0, 0, 1'b0);
    adv(2100, 2, 28, 23, 59, 59,  2100, 3, 1, 0, 0, 0, 1'b0);
    adv(2000, 2, 28, 23, 59, 59,  2000, 2, 29, 0, 0, 0, 1'b0);
    adv(0, 2, 28, 23, 59, 59,     0, 2, 29, 0, 0, 0, 1'b0);
    adv(2023, 4, 30, 23, 59, 59,  2023, 5, 1, 0, 0, 0, 1'b0);
    adv(2023, 1, 31, 12, 59, 59,  2023, 1, 31, 13, 0, 0, 1'b0);
    adv(9999, 12, 31, 23, 59, 59, 0, 1, 1, 0, 0, 0, 1'b0);
    adv(2023, 7, 4, 7, 29, 59,    2023, 7, 4, 7, 30, 0, AL);

    // Direct load onto the alarm time: no alarm, no tick
    set_ld(2023, 7, 4, 7, 30, 0);
    load1 = 1'b1;
    step(1);
    snap1.push_back(mk(1'b0, 1'b0, 1'b0, 2023, 7, 4, 7, 30, 0));
    load1 = 1'b0;
    step(2);
    cur1 = mk(1'b0, 1'b0, 1'b0, 2023, 7, 4, 7, 30, 0);

    bad_load(2023, 2, 29, 0, 0, 0);
    bad_load(2023, 13, 1, 0, 0, 0);
    bad_load(2023, 1, 1, 0, 0, 60);
    bad_load(2023, 1, 1, 0, 60, 0);
    bad_load(2023, 1, 1, 24, 0, 0);
    bad_load(2023, 1, 0, 0, 0, 0);
    bad_load(2023, 4, 31, 0, 0, 0);
    bad_load(10000, 1, 1, 0, 0, 0);
    bad_load(2023, 0, 1, 0, 0, 0);

    // Rejected load while running: the advance still happens
    set_ld(2023, 1, 1, 0, 0, 60);
    q1.push_back(mk(1'b1, 1'b1, 1'b0, 2023, 7, 4, 7, 30, 1));
    load1 = 1'b1; run1 = 1'b1;
    step(1);
    load1 = 1'b0; run1 = 1'b0;
    step(1);

    // Valid load on an advancing edge wins
    set_ld(2024, 12, 31, 23, 59, 59);
    load1 = 1'b1; run1 = 1'b1;
    step(1);
    snap1.push_back(mk(1'b0, 1'b0, 1'b0, 2024, 12, 31, 23, 59, 59));
    load1 = 1'b0; run1 = 1'b0;
    step(2);

    // Four ticks per second: pause keeps the prescaler
    run4 = 1'b1; step(3);
    run4 = 1'b0; step(5);
    q4.push_back(mk(1'b1, 1'b0, 1'b0, 2000, 1, 1, 0, 0, 1));
    run4 = 1'b1; step(1);
    run4 = 1'b0; step(1);

    // Load on the advancing edge, then a full fresh prescaler period
    run4 = 1'b1; step(3);
    set_ld(2024, 6, 15, 10, 20, 30);
    load4 = 1'b1;
    step(1);
    snap4.push_back(mk(1'b0, 1'b0, 1'b0, 2024, 6, 15, 10, 20, 30));
    load4 = 1'b0;
    step(3);
    snap4.push_back(mk(1'b0, 1'b0, 1'b0, 2024, 6, 15, 10, 20, 30));
    q4.push_back(mk(1'b1, 1'b0, 1'b0, 2024, 6, 15, 10, 20, 31));
    step(1);
    run4 = 1'b0;
    step(1);

    // Reset mid-run with a load pending
    strict = 1'b0;
    run1 = 1'b1;
    step(3);
    rst_n = 1'b0;
    set_ld(2024, 1, 1, 1, 1, 1);
    load1 = 1'b1;
    snap1.push_back(mk(1'b0, 1'b0, 1'b0, 2000, 1, 1, 0, 0, 0));
    snap4.push_back(mk(1'b0, 1'b0, 1'b0, 2000, 1, 1, 0, 0, 0));
    step(2);
    load1 = 1'b0; run1 = 1'b0;
    rst_n = 1'b1;
    snap1.push_back(mk(1'b0, 1'b0, 1'b0, 2000, 1, 1, 0, 0, 0));
    step(2);

    req_drain = 1'b1;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
